// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with prioritised dual write, same-cycle bypass
// and a per-register pending scoreboard for ID-stage hazard detection.
module reg_file_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_READ = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       wrEn0,
   input  logic [ADDR_W-1:0]          wrAddr0,
   input  logic [DATA_W-1:0]          wrData0,
   input  logic                       wrEn1,
   input  logic [ADDR_W-1:0]          wrAddr1,
   input  logic [DATA_W-1:0]          wrData1,
   input  logic                       issueEn,
   input  logic [ADDR_W-1:0]          issueAddr,
   input  logic [NUM_READ*ADDR_W-1:0] rdAddr,
   output logic [NUM_READ*DATA_W-1:0] rdData,
   output logic [NUM_READ-1:0]        rdBusy
);
   localparam int DEPTH = 1 << ADDR_W;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  pending;
   logic              we0, we1;
   assign we0 = wrEn0 && !(ZERO_REG != 0 && wrAddr0 == '0);
   assign we1 = wrEn1 && !(ZERO_REG != 0 && wrAddr1 == '0);
   // port 1 is written last so it wins a same-address collision
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int a = 0; a < DEPTH; a++) mem[a] <= '0;
         pending <= '0;
      end else begin
         if (we0) mem[wrAddr0] <= wrData0;
         if (we1) mem[wrAddr1] <= wrData1;
         for (int a = 0; a < DEPTH; a++)
            if (issueEn && issueAddr == ADDR_W'(a)) pending[a] <= 1'b1;
            else if ((wrEn0 && wrAddr0 == ADDR_W'(a)) || (wrEn1 && wrAddr1 == ADDR_W'(a))) pending[a] <= 1'b0;
         if (ZERO_REG != 0) pending[0] <= 1'b0;
      end
   end
   for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              z, h1, h0;
      assign ra = rdAddr[i*ADDR_W +: ADDR_W];
      assign z  = ZERO_REG != 0 && ra == '0;
      assign h1 = wrEn1 && wrAddr1 == ra;
      assign h0 = wrEn0 && wrAddr0 == ra;
      assign rdData[i*DATA_W +: DATA_W] = z ? '0 : h1 ? wrData1 : h0 ? wrData0 : mem[ra];
      assign rdBusy[i] = !z && !h1 && !h0 && pending[ra];
   end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed checks of reset, write/bypass, port priority, zero register,
// scoreboard and reset override for reg_file_mp (default parameters).
module tb_reg_file_mp;
   logic        clock = 0;
   logic        reset = 1;
   logic        wrEn0 = 0, wrEn1 = 0, issueEn = 0;
   logic [4:0]  wrAddr0 = 0, wrAddr1 = 0, issueAddr = 0;
   logic [31:0] wrData0 = 0, wrData1 = 0;
   logic [9:0]  rdAddr = 0;
   logic [63:0] rdData;
   logic [1:0]  rdBusy;
   int total = 0, bad = 0;

   reg_file_mp dut (
      .clock(clock), .reset(reset),
      .wrEn0(wrEn0), .wrAddr0(wrAddr0), .wrData0(wrData0),
      .wrEn1(wrEn1), .wrAddr1(wrAddr1), .wrData1(wrData1),
      .issueEn(issueEn), .issueAddr(issueAddr),
      .rdAddr(rdAddr), .rdData(rdData), .rdBusy(rdBusy)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(negedge clock);
   endtask

   task automatic test_reset();
      reset = 1;
      step();
      reset = 0;
      for (int a = 0; a < 32; a++) begin
         rdAddr = {5'(a), 5'(31 - a)};
         #1;
         total++;
         if (rdData !== 64'h0) begin bad++; $display("FAIL reset_data addr=%0d got=%h want=0", a, rdData); end
         total++;
         if (rdBusy !== 2'b00) begin bad++; $display("FAIL reset_busy addr=%0d got=%b want=00", a, rdBusy); end
      end
   endtask

   task automatic test_write_bypass();
      step();
      wrEn0 = 1; wrAddr0 = 5; wrData0 = 32'hDEAD_BEEF; rdAddr = {5'd0, 5'd5};
      #1;
      total++;
      if (rdData[31:0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bypass0 got=%h want=deadbeef", rdData[31:0]); end
      step();
      wrEn0 = 0;
      #1;
      total++;
      if (rdData[31:0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL stored0 got=%h want=deadbeef", rdData[31:0]); end
   endtask

   task automatic test_dual_write();
      step();
      wrEn0 = 1; wrAddr0 = 7; wrData0 = 32'h1111_1111;
      wrEn1 = 1; wrAddr1 = 7; wrData1 = 32'h2222_2222;
      rdAddr = {5'd7, 5'd5};
      #1;
      total++;
      if (rdData[63:32] !== 32'h2222_2222) begin bad++; $display("FAIL dual_bypass got=%h want=22222222", rdData[63:32]); end
      step();
      wrEn0 = 0; wrEn1 = 0;
      #1;
      total++;
      if (rdData[63:32] !== 32'h2222_2222) begin bad++; $display("FAIL dual_stored got=%h want=22222222", rdData[63:32]); end
      total++;
      if (rdData[31:0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL addr5_kept got=%h want=deadbeef", rdData[31:0]); end
   endtask

   task automatic test_zero_reg();
      step();
      wrEn1 = 1; wrAddr1 = 0; wrData1 = 32'hFFFF_FFFF; issueEn = 1; issueAddr = 0;
      rdAddr = {5'd0, 5'd0};
      #1;
      total++;
      if (rdData !== 64'h0 || rdBusy !== 2'b00) begin bad++; $display("FAIL zero_same got=%h/%b want=0/00", rdData, rdBusy); end
      step();
      wrEn1 = 0; issueEn = 0;
      #1;
      total++;
      if (rdData !== 64'h0 || rdBusy !== 2'b00) begin bad++; $display("FAIL zero_next got=%h/%b want=0/00", rdData, rdBusy); end
   endtask

   task automatic test_scoreboard();
      step();
      issueEn = 1; issueAddr = 9; rdAddr = {5'd7, 5'd9};
      #1;
      total++;
      if (rdBusy[0] !== 1'b0) begin bad++; $display("FAIL issue_same busy got=%b want=0", rdBusy[0]); end
      step();
      issueEn = 0;
      #1;
      total++;
      if (rdBusy !== 2'b01) begin bad++; $display("FAIL issue_next busy got=%b want=01", rdBusy); end
      step();
      wrEn0 = 1; wrAddr0 = 9; wrData0 = 32'h42;
      #1;
      total++;
      if (rdBusy[0] !== 1'b0 || rdData[31:0] !== 32'h42) begin bad++; $display("FAIL wb_bypass got=%b/%h want=0/42", rdBusy[0], rdData[31:0]); end
      step();
      wrEn0 = 0;
      #1;
      total++;
      if (rdBusy[0] !== 1'b0 || rdData[31:0] !== 32'h42) begin bad++; $display("FAIL wb_cleared got=%b/%h want=0/42", rdBusy[0], rdData[31:0]); end
      step();
      issueEn = 1; issueAddr = 9; wrEn1 = 1; wrAddr1 = 9; wrData1 = 32'h43;
      #1;
      total++;
      if (rdBusy[0] !== 1'b0 || rdData[31:0] !== 32'h43) begin bad++; $display("FAIL issue_wr_same got=%b/%h want=0/43", rdBusy[0], rdData[31:0]); end
      step();
      issueEn = 0; wrEn1 = 0;
      #1;
      total++;
      if (rdBusy[0] !== 1'b1 || rdData[31:0] !== 32'h43) begin bad++; $display("FAIL issue_wins got=%b/%h want=1/43", rdBusy[0], rdData[31:0]); end
      step();
      issueEn = 1; issueAddr = 9;
      step();
      issueEn = 0; wrEn0 = 1; wrAddr0 = 9; wrData0 = 32'h44;
      step();
      wrEn0 = 0;
      #1;
      total++;
      if (rdBusy[0] !== 1'b0 || rdData[31:0] !== 32'h44) begin bad++; $display("FAIL double_issue got=%b/%h want=0/44", rdBusy[0], rdData[31:0]); end
   endtask

   task automatic test_reset_override();
      step();
      wrEn0 = 1; wrAddr0 = 3; wrData0 = 32'h55; issueEn = 1; issueAddr = 4;
      step();
      wrEn0 = 0; issueEn = 0; rdAddr = {5'd4, 5'd3};
      #1;
      total++;
      if (rdData[31:0] !== 32'h55 || rdBusy !== 2'b10) begin bad++; $display("FAIL pre_reset got=%h/%b want=55/10", rdData[31:0], rdBusy); end
      step();
      reset = 1; wrEn0 = 1; wrAddr0 = 3; wrData0 = 32'h66;
      step();
      reset = 0; wrEn0 = 0;
      #1;
      total++;
      if (rdData !== 64'h0 || rdBusy !== 2'b00) begin bad++; $display("FAIL reset_override got=%h/%b want=0/00", rdData, rdBusy); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp [4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
      for (int k = 0; k < 4; k++) begin
         step();
         wrEn0 = (k % 2 == 0); wrAddr0 = 5'(10 + k); wrData0 = exp[k];
         wrEn1 = (k % 2 == 1); wrAddr1 = 5'(10 + k); wrData1 = exp[k];
      end
      step();
      wrEn0 = 0; wrEn1 = 0;
      for (int k = 0; k < 4; k += 2) begin
         rdAddr = {5'(11 + k), 5'(10 + k)};
         #1;
         total++;
         if (rdData !== {exp[k+1], exp[k]}) begin bad++; $display("FAIL b2b k=%0d got=%h want=%h", k, rdData, {exp[k+1], exp[k]}); end
      end
   endtask

   initial begin
      test_reset();
      test_write_bypass();
      test_dual_write();
      test_zero_reg();
      test_scoreboard();
      test_reset_override();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
